// File: rtl/cpu_harness_pkg.sv
// Shared types and constants for the CPU test-harness run/halt/dump controller.
`timescale 1ns/1ps
package cpu_harness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DUMP_RD,
        ST_DUMP_CAP,
        ST_DUMP_OUT,
        ST_DONE
    } ctrl_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Each dumped word costs read, capture and present cycles.
    localparam int DUMP_CYCLES_PER_WORD = 3;

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready holding register for one dumped word: loaded from the capture
// cycle, held stable under backpressure, released on handshake.
`timescale 1ns/1ps
module dump_out_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // Data and address persist after the handshake; last only accompanies valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            addr  <= load_addr;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_halt_dump_ctrl.sv
// Run/halt controller for the pipelined CPU harness: runs the CPU until the halt
// sentinel or a timeout, drains the pipeline, then streams out the data RAM.
`timescale 1ns/1ps
module cpu_halt_dump_ctrl
    import cpu_harness_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = 9,
    parameter int          DUMP_DEPTH   = 512,
    parameter int          DRAIN_CYCLES = 10,
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instr_id,
    input  logic [CNT_W-1:0]  timeout_limit,
    output logic              cpu_run,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int                DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DUMP_DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    ctrl_state_t        state;
    ctrl_state_t        next_state;
    logic [ADDR_W-1:0]  ptr;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               halt_hit;
    logic               timeout_hit;
    logic               ptr_last;
    logic               handshake;
    logic               cap_load;

    // Case equality keeps an unknown ID-stage word from ever reading as a halt.
    assign halt_hit    = (instr_id === HALT_WORD);
    assign timeout_hit = (timeout_limit != '0) && (cycle_count == timeout_limit - CNT_W'(1));
    assign ptr_last    = (ptr == LAST_ADDR);
    assign handshake   = dump_valid && dump_ready;
    assign mem_rd_addr = mem_rd_en ? ptr : '0;
    assign done        = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cpu_run    = 1'b0;
        mem_rd_en  = 1'b0;
        cap_load   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) next_state = ST_RUN;
            end
            ST_RUN: begin
                cpu_run = 1'b1;
                if (halt_hit || timeout_hit)
                    next_state = (DRAIN_CYCLES == 0) ? ST_DUMP_RD : ST_DRAIN;
            end
            ST_DRAIN: begin
                cpu_run = 1'b1;
                if (drain_cnt <= DRAIN_W'(1)) next_state = ST_DUMP_RD;
            end
            ST_DUMP_RD: begin
                mem_rd_en  = 1'b1;
                next_state = ST_DUMP_CAP;
            end
            ST_DUMP_CAP: begin
                cap_load   = 1'b1;
                next_state = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (handshake) next_state = ptr_last ? ST_DONE : ST_DUMP_RD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Halt takes priority over a coincident timeout, so timed_out stays clear then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            drain_cnt   <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cycle_count <= '0;
                        timed_out   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_hit) begin
                        drain_cnt <= DRAIN_LOAD;
                        ptr       <= '0;
                    end else if (timeout_hit) begin
                        drain_cnt <= DRAIN_LOAD;
                        ptr       <= '0;
                        timed_out <= 1'b1;
                    end else if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                ST_DUMP_OUT: begin
                    if (handshake && !ptr_last) ptr <= ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    dump_out_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (cap_load),
        .load_data (mem_rd_data),
        .load_addr (ptr),
        .load_last (ptr_last),
        .ready     (dump_ready),
        .valid     (dump_valid),
        .data      (dump_data),
        .addr      (dump_addr),
        .last      (dump_last)
    );

endmodule

// File: tb/tb_cpu_halt_dump_ctrl.sv
// Directed bench for cpu_halt_dump_ctrl: one instance with a 10-cycle drain and
// one with no drain, both dumping a 4-word RAM whose word i is A000_0000+i.
`timescale 1ns/1ps
module tb_cpu_halt_dump_ctrl;
    import cpu_harness_pkg::*;

    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 9;
    localparam int          DUMP_DEPTH = 4;
    localparam int          CNT_W      = 32;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_a, start_b;
    logic [31:0]       instr_id;
    logic [CNT_W-1:0]  timeout_limit;
    logic              dump_ready;
    logic              use_b;

    logic              a_cpu_run, a_mem_rd_en, a_dump_valid, a_dump_last, a_done, a_timed_out;
    logic [ADDR_W-1:0] a_mem_rd_addr, a_dump_addr;
    logic [DATA_W-1:0] a_mem_rd_data, a_dump_data;
    logic [CNT_W-1:0]  a_cycle_count;
    logic              b_cpu_run, b_mem_rd_en, b_dump_valid, b_dump_last, b_done, b_timed_out;
    logic [ADDR_W-1:0] b_mem_rd_addr, b_dump_addr;
    logic [DATA_W-1:0] b_mem_rd_data, b_dump_data;
    logic [CNT_W-1:0]  b_cycle_count;

    logic              o_run, o_rd_en, o_valid, o_last, o_done, o_timed;
    logic [ADDR_W-1:0] o_rd_addr, o_addr;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cpu_halt_dump_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DUMP_DEPTH(DUMP_DEPTH),
        .DRAIN_CYCLES(10), .HALT_WORD(HALT_WORD_DEFAULT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .instr_id(instr_id),
        .timeout_limit(timeout_limit), .cpu_run(a_cpu_run), .mem_rd_en(a_mem_rd_en),
        .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data), .dump_valid(a_dump_valid),
        .dump_ready(dump_ready), .dump_data(a_dump_data), .dump_addr(a_dump_addr),
        .dump_last(a_dump_last), .done(a_done), .timed_out(a_timed_out),
        .cycle_count(a_cycle_count)
    );

    cpu_halt_dump_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DUMP_DEPTH(DUMP_DEPTH),
        .DRAIN_CYCLES(0), .HALT_WORD(HALT_WORD_DEFAULT), .CNT_W(CNT_W)
    ) u_dut_nodrain (
        .clk(clk), .reset(reset), .start(start_b), .instr_id(instr_id),
        .timeout_limit(timeout_limit), .cpu_run(b_cpu_run), .mem_rd_en(b_mem_rd_en),
        .mem_rd_addr(b_mem_rd_addr), .mem_rd_data(b_mem_rd_data), .dump_valid(b_dump_valid),
        .dump_ready(dump_ready), .dump_data(b_dump_data), .dump_addr(b_dump_addr),
        .dump_last(b_dump_last), .done(b_done), .timed_out(b_timed_out),
        .cycle_count(b_cycle_count)
    );

    // Synchronous RAM models: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (a_mem_rd_en) a_mem_rd_data <= 32'hA000_0000 + 32'(a_mem_rd_addr);
        if (b_mem_rd_en) b_mem_rd_data <= 32'hA000_0000 + 32'(b_mem_rd_addr);
    end

    always_comb begin
        o_run     = use_b ? b_cpu_run     : a_cpu_run;
        o_rd_en   = use_b ? b_mem_rd_en   : a_mem_rd_en;
        o_rd_addr = use_b ? b_mem_rd_addr : a_mem_rd_addr;
        o_valid   = use_b ? b_dump_valid  : a_dump_valid;
        o_data    = use_b ? b_dump_data   : a_dump_data;
        o_addr    = use_b ? b_dump_addr   : a_dump_addr;
        o_last    = use_b ? b_dump_last   : a_dump_last;
        o_done    = use_b ? b_done        : a_done;
        o_timed   = use_b ? b_timed_out   : a_timed_out;
        o_count   = use_b ? b_cycle_count : a_cycle_count;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic rdy, input logic strt);
        instr_id   = instr;
        dump_ready = rdy;
        start_a    = strt && !use_b;
        start_b    = strt && use_b;
    endtask

    // One complete start -> run -> drain -> dump -> done pass on the selected instance.
    task automatic runToDone(input string name, input int halt_at, input int exp_exit,
                             input int drain, input logic exp_timed, input int stall_addr,
                             input int stall_len, input bit poke_start);
        int   run_cycles  = 0;
        int   first_rd    = -1;
        int   rd_count_at = -1;
        int   words       = 0;
        int   stalls      = 0;
        int   rd_total    = 0;
        int   done_at     = -1;
        int   exp_rd      = exp_exit + 1 + drain;
        logic rdy;
        logic strt;
        applyStimulus(NOP, 1'b1, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            rdy  = !(o_valid && o_addr == ADDR_W'(stall_addr) && stalls < stall_len);
            strt = poke_start && o_valid;
            applyStimulus((k == halt_at) ? HALT_WORD_DEFAULT : NOP, rdy, strt);
            @(negedge clk);
            if (k == 0) begin
                checkOutput({name, ".start_done_clr"}, 64'(o_done), 64'(0));
                checkOutput({name, ".start_cnt_clr"}, 64'(o_count), 64'(0));
                checkOutput({name, ".start_tmo_clr"}, 64'(o_timed), 64'(0));
            end
            if (o_run) run_cycles++;
            if (o_rd_en) begin
                if (first_rd < 0) begin
                    first_rd    = k;
                    rd_count_at = int'(o_count);
                end
                checkOutput({name, ".rd_addr"}, 64'(o_rd_addr), 64'(words));
                rd_total++;
            end
            if (o_valid && !rdy) begin
                stalls++;
                checkOutput({name, ".stall_data"}, 64'(o_data), 64'(32'hA000_0000 + 32'(stall_addr)));
                checkOutput({name, ".stall_addr"}, 64'(o_addr), 64'(stall_addr));
            end else if (o_valid) begin
                checkOutput({name, ".word_data"}, 64'(o_data), 64'(32'hA000_0000 + 32'(words)));
                checkOutput({name, ".word_addr"}, 64'(o_addr), 64'(words));
                checkOutput({name, ".word_last"}, 64'(o_last), 64'(words == DUMP_DEPTH - 1));
                words++;
            end
            if (o_done) done_at = k;
            @(posedge clk); #1;
        end
        applyStimulus(NOP, 1'b1, 1'b0);
        checkOutput({name, ".run_cycles"}, 64'(run_cycles), 64'(exp_rd));
        checkOutput({name, ".first_rd"}, 64'(first_rd), 64'(exp_rd));
        checkOutput({name, ".count_at_rd"}, 64'(rd_count_at), 64'(exp_exit));
        checkOutput({name, ".words"}, 64'(words), 64'(DUMP_DEPTH));
        checkOutput({name, ".reads"}, 64'(rd_total), 64'(DUMP_DEPTH));
        checkOutput({name, ".stalls"}, 64'(stalls), 64'(stall_len));
        checkOutput({name, ".done_at"}, 64'(done_at),
                    64'(exp_rd + DUMP_DEPTH * DUMP_CYCLES_PER_WORD + stall_len));
        checkOutput({name, ".done"}, 64'(o_done), 64'(1));
        checkOutput({name, ".timed_out"}, 64'(o_timed), 64'(exp_timed));
        checkOutput({name, ".final_count"}, 64'(o_count), 64'(exp_exit));
    endtask

    initial begin
        int found;
        int valid_cycles;
        int run_cycles;
        use_b         = 1'b0;
        timeout_limit = '0;
        reset         = 1'b1;
        applyStimulus(NOP, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset.cpu_run", 64'(a_cpu_run), 64'(0));
        checkOutput("reset.done", 64'(a_done), 64'(0));
        checkOutput("reset.valid", 64'(a_dump_valid), 64'(0));
        checkOutput("reset.count", 64'(a_cycle_count), 64'(0));
        checkOutput("reset.rd_en", 64'(a_mem_rd_en), 64'(0));
        checkOutput("reset.b_run", 64'(b_cpu_run), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        runToDone("halt", 20, 20, 10, 1'b0, -1, 0, 1'b0);
        runToDone("bp", 3, 3, 10, 1'b0, 1, 5, 1'b0);
        timeout_limit = 32'd8;
        runToDone("tmo", -1, 7, 10, 1'b1, -1, 0, 1'b0);
        runToDone("tmo_halt", 7, 7, 10, 1'b0, -1, 0, 1'b0);
        timeout_limit = '0;
        use_b = 1'b1;
        runToDone("nodrain", 5, 5, 0, 1'b0, -1, 0, 1'b1);
        runToDone("nodrain_re", 2, 2, 0, 1'b0, 1, 2, 1'b0);

        // Asynchronous reset while word 2 sits in DUMP_OUT.
        use_b = 1'b0;
        applyStimulus(NOP, 1'b1, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus((k == 3) ? HALT_WORD_DEFAULT : NOP, 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        applyStimulus(NOP, 1'b1, 1'b0);
        found = 0;
        for (int k = 0; k < 80 && found == 0; k++) begin
            @(negedge clk);
            if (o_valid && o_addr == ADDR_W'(2)) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkOutput("rst.word2_seen", 64'(found), 64'(1));
        checkOutput("rst.count_before", 64'(o_count), 64'(3));
        #2 reset = 1'b1;
        #1;
        checkOutput("rst.cpu_run", 64'(o_run), 64'(0));
        checkOutput("rst.rd_en", 64'(o_rd_en), 64'(0));
        checkOutput("rst.rd_addr", 64'(o_rd_addr), 64'(0));
        checkOutput("rst.valid", 64'(o_valid), 64'(0));
        checkOutput("rst.data", 64'(o_data), 64'(0));
        checkOutput("rst.addr", 64'(o_addr), 64'(0));
        checkOutput("rst.last", 64'(o_last), 64'(0));
        checkOutput("rst.done", 64'(o_done), 64'(0));
        checkOutput("rst.timed_out", 64'(o_timed), 64'(0));
        checkOutput("rst.count", 64'(o_count), 64'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        valid_cycles = 0;
        run_cycles   = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_valid) valid_cycles++;
            if (o_run) run_cycles++;
        end
        checkOutput("rst.no_valid_after", 64'(valid_cycles), 64'(0));
        checkOutput("rst.no_run_after", 64'(run_cycles), 64'(0));
        checkOutput("rst.idle_done", 64'(o_done), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
